// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the two-requester data-bus arbiter: request/response structs, requester id, lock state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dbus_arbiter_pkg;

    // Requester index (two requesters -> one bit)
    typedef logic arb_id_t;

    localparam int ARB_NREQ = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    // LOCK_HELD: the presented request has not yet seen addr_ok and must stay selected
    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    function automatic arb_id_t arb_other(arb_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Data-bus request/response pair; master drives dreq, slave answers on dresp.
// Latency: n/a (wiring only).
// Backpressure: addr_ok accepts a request, data_ok returns its data later.
interface dbus_arbiter_if;
    import dbus_arbiter_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_arbiter_order_fifo.sv
// Order FIFO of requester ids for accepted requests still awaiting data_ok.
// Latency: push visible at head one cycle later; head_id/count/full/empty are registered-state views.
// Backpressure: none internally; the caller must not push when full or pop when empty.
// Ports: clk, resetn (sync, active-low), push/push_id, pop, head_id, count, full, empty.
module arb_order_fifo
    import dbus_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  arb_id_t       push_id,
    input  logic          pop,
    output arb_id_t       head_id,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    arb_id_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_id;
    end

    assign head_id = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one MMU data-bus port between two requesters and routes data_ok back in issue order.
// Latency: zero cycles in both directions (request and response paths are combinational).
// Backpressure: forwarded valid drops while MAX_INFLIGHT requests await data_ok; an un-acked request stays locked.
// Ports: clk, resetn (sync, active-low), port_0/port_1 (requester side), mmu (MMU side),
//        inflight (order FIFO occupancy), orphan_err (sticky: data_ok seen with nothing outstanding).
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter  int MAX_INFLIGHT = 4,
    localparam int CW           = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    dbus_arbiter_if.slave          port_0,
    dbus_arbiter_if.slave          port_1,
    dbus_arbiter_if.master         mmu,
    output logic [CW-1:0]          inflight,
    output logic                   orphan_err
);

    lock_state_e state_q, state_d;
    arb_id_t     lock_id_q, lock_id_d;
    arb_id_t     rr_ptr_q, rr_ptr_d;
    logic        orphan_q;

    dbus_req_t   req0, req1, sel_req, arb_req;
    dbus_resp_t  resp [ARB_NREQ];
    arb_id_t     sel;
    logic        any_sel;

    logic        full, empty;
    arb_id_t     head_id;
    logic        accept, data_ok_in, bypass;
    logic        fifo_push, fifo_pop;
    logic        route_vld;
    arb_id_t     route_id;
    logic        orphan_set;

    assign req0 = port_0.dreq;
    assign req1 = port_1.dreq;

    // Selection: a locked request wins outright; otherwise round-robin only matters when both are valid
    always_comb begin
        sel     = '0;
        any_sel = 1'b0;
        if (state_q == LOCK_HELD) begin
            sel     = lock_id_q;
            any_sel = 1'b1;
        end else if (req0.valid && req1.valid) begin
            sel     = rr_ptr_q;
            any_sel = 1'b1;
        end else if (req1.valid) begin
            sel     = 1'b1;
            any_sel = 1'b1;
        end else if (req0.valid) begin
            sel     = 1'b0;
            any_sel = 1'b1;
        end
    end

    assign sel_req = sel ? req1 : req0;

    always_comb begin
        arb_req = '0;
        if (resetn && any_sel) begin
            arb_req       = sel_req;
            arb_req.valid = sel_req.valid & ~full;
        end
    end

    assign mmu.dreq = arb_req;

    assign accept     = arb_req.valid & mmu.dresp.addr_ok;
    assign data_ok_in = mmu.dresp.data_ok & resetn;

    // Same-cycle accept and data_ok with nothing outstanding: answer directly, never touch the FIFO
    assign bypass     = empty & accept & data_ok_in;
    assign fifo_push  = accept & ~bypass;
    assign fifo_pop   = data_ok_in & ~empty;
    assign route_vld  = bypass | fifo_pop;
    assign route_id   = bypass ? sel : head_id;
    assign orphan_set = data_ok_in & empty & ~bypass;

    arb_order_fifo #(
        .DEPTH   (MAX_INFLIGHT)
    ) u_order_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (fifo_push),
        .push_id (sel),
        .pop     (fifo_pop),
        .head_id (head_id),
        .count   (inflight),
        .full    (full),
        .empty   (empty)
    );

    // Response demux: data always fans out, only the owning requester sees the strobes
    always_comb begin
        for (int i = 0; i < ARB_NREQ; i++) begin
            resp[i]         = '0;
            resp[i].data    = mmu.dresp.data;
            resp[i].addr_ok = accept && (sel == arb_id_t'(i));
            resp[i].data_ok = route_vld && (route_id == arb_id_t'(i));
        end
    end

    assign port_0.dresp = resp[0];
    assign port_1.dresp = resp[1];

    // Lock / round-robin next state
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            state_d  = LOCK_IDLE;
            rr_ptr_d = arb_other(sel);
        end else if (arb_req.valid) begin
            state_d   = LOCK_HELD;
            lock_id_d = sel;
        end else if ((state_q == LOCK_HELD) && !sel_req.valid) begin
            // locked requester withdrew; preference is left where it was
            state_d = LOCK_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= LOCK_IDLE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            orphan_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            orphan_q  <= orphan_q | orphan_set;
        end
    end

    assign orphan_err = orphan_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: stimulus predicts each cycle's outputs into a queue, a negedge monitor checks.
// Latency: expectations are per cycle; inputs change just after posedge, checks happen at negedge.
// Backpressure: the bench plays both requesters and the MMU (addr_ok/data_ok chosen per scenario or randomly).
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

    localparam int MAXI = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] inflight;
    logic       orphan_err;

    always #5 clk = ~clk;

    dbus_arbiter_if bus0();
    dbus_arbiter_if bus1();
    dbus_arbiter_if mmu();

    dbus_arbiter #(.MAX_INFLIGHT(MAXI)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .port_0     (bus0),
        .port_1     (bus1),
        .mmu        (mmu),
        .inflight   (inflight),
        .orphan_err (orphan_err)
    );

    typedef struct {
        bit          a_vld;
        logic [31:0] a_addr;
        bit          ok0, ok1, d0, d1;
        logic [31:0] ddat;
        int          cnt;
        bit          orph;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: outstanding requests as a queue of issuer ids, plus who currently holds the bus
    bit          m_q[$];
    bit          m_pref = 1'b0;
    bit          m_own_vld = 1'b0;
    bit          m_own = 1'b0;
    bit          m_orph = 1'b0;

    bit          want [2];
    logic [31:0] addr_ctr [2];
    bit          last_acc;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic dbus_req_t mk_req(int i);
        dbus_req_t r;
        r        = '0;
        r.valid  = want[i];
        r.addr   = addr_ctr[i];
        r.size   = 3'd2;
        r.strobe = (i == 1) ? 4'hF : 4'h0;
        r.data   = addr_ctr[i] ^ 32'h5A5A_0000;
        return r;
    endfunction

    // One bus cycle: apply inputs, predict outputs, advance model, step past the clock edge
    task automatic cyc(bit rst_n_v, bit aok, bit dok, logic [31:0] dd);
        dbus_req_t rq [2];
        exp_t      e;
        bit        sel, any, fwd, acc, byp;
        rq[0] = mk_req(0);
        rq[1] = mk_req(1);
        resetn             = rst_n_v;
        bus0.dreq          = rq[0];
        bus1.dreq          = rq[1];
        mmu.dresp.addr_ok  = aok;
        mmu.dresp.data_ok  = dok;
        mmu.dresp.data     = dd;

        e.a_vld = 0; e.a_addr = '0; e.ok0 = 0; e.ok1 = 0; e.d0 = 0; e.d1 = 0;
        e.ddat  = dd;
        e.cnt   = m_q.size();
        e.orph  = m_orph;
        sel = 0; acc = 0;

        if (!rst_n_v) begin
            m_q.delete();
            m_own_vld = 0;
            m_pref    = 0;
            m_orph    = 0;
        end else begin
            if (m_own_vld) begin
                sel = m_own; any = 1;
            end else if (rq[0].valid && rq[1].valid) begin
                sel = m_pref; any = 1;
            end else if (rq[1].valid) begin
                sel = 1; any = 1;
            end else begin
                sel = 0; any = rq[0].valid;
            end
            fwd      = any && rq[sel].valid && (m_q.size() < MAXI);
            e.a_vld  = fwd;
            e.a_addr = rq[sel].addr;
            acc      = fwd && aok;
            e.ok0    = acc && !sel;
            e.ok1    = acc && sel;
            byp      = acc && dok && (m_q.size() == 0);
            if (dok) begin
                if (byp) begin
                    if (sel) e.d1 = 1; else e.d0 = 1;
                end else if (m_q.size() > 0) begin
                    if (m_q[0]) e.d1 = 1; else e.d0 = 1;
                    void'(m_q.pop_front());
                end else begin
                    m_orph = 1;
                end
            end
            if (acc && !byp) m_q.push_back(sel);
            if (acc) begin
                m_own_vld = 0;
                m_pref    = !sel;
            end else if (fwd) begin
                m_own_vld = 1;
                m_own     = sel;
            end else if (m_own_vld && !rq[sel].valid) begin
                m_own_vld = 0;
            end
        end
        exp_q.push_back(e);
        last_acc = acc;
        @(posedge clk);
        #1;
        if (acc) addr_ctr[sel] = addr_ctr[sel] + 32'h10;
    endtask

    task automatic drain();
        want[0] = 0;
        want[1] = 0;
        for (int i = 0; i < 2 * MAXI && m_q.size() > 0; i++)
            cyc(1, 0, 1, $urandom);
    endtask

    // Monitor: one expectation per cycle, compared against what the DUT presents
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("arb_valid", {31'd0, mmu.dreq.valid}, {31'd0, e.a_vld});
            if (e.a_vld) chk("arb_addr", mmu.dreq.addr, e.a_addr);
            chk("addr_ok_0", {31'd0, bus0.dresp.addr_ok}, {31'd0, e.ok0});
            chk("addr_ok_1", {31'd0, bus1.dresp.addr_ok}, {31'd0, e.ok1});
            chk("data_ok_0", {31'd0, bus0.dresp.data_ok}, {31'd0, e.d0});
            chk("data_ok_1", {31'd0, bus1.dresp.data_ok}, {31'd0, e.d1});
            chk("data_0", bus0.dresp.data, e.ddat);
            chk("data_1", bus1.dresp.data, e.ddat);
            chk("inflight", {29'd0, inflight}, e.cnt);
            chk("orphan_err", {31'd0, orphan_err}, {31'd0, e.orph});
        end
    end

    initial begin
        int n;
        want[0] = 0; want[1] = 0;
        addr_ctr[0] = 32'h0000_1000;
        addr_ctr[1] = 32'h0000_2000;
        bus0.dreq = '0;
        bus1.dreq = '0;
        mmu.dresp = '0;
        @(posedge clk);
        #1;

        // reset held with both requesters valid and MMU strobes high
        want[0] = 1; want[1] = 1;
        repeat (2) cyc(0, 1, 1, 32'hDEAD_BEEF);

        // both valid, addr_ok every cycle: grants alternate, data_ok two cycles later
        for (int k = 0; k < 6; k++)
            cyc(1, k < 4, k >= 2, (k >= 2) ? (32'hA0 + 32'h11 * (k - 2)) : 32'h0);

        // req0 held without addr_ok while req1 arrives; lock keeps req0 on the bus
        want[1] = 0;
        cyc(1, 0, 0, 0);
        want[1] = 1;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        want[0] = 0;
        cyc(1, 1, 0, 0);

        // locked requester withdraws: lock released, other requester granted next
        want[1] = 0; want[0] = 1;
        cyc(1, 0, 0, 0);
        want[0] = 0; want[1] = 1;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        drain();

        // fill to MAX_INFLIGHT, one data_ok, then keep going through pointer wrap
        want[0] = 1; want[1] = 1;
        repeat (6) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 32'h0F0F_0001);
        cyc(1, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            cyc(1, 1, ($urandom_range(0, 1) == 1) && (m_q.size() > 0), $urandom);
            if (last_acc) n++;
        end
        drain();

        // random traffic, data_ok only while something is outstanding
        for (int i = 0; i < 400; i++) begin
            want[0] = ($urandom_range(0, 3) != 0);
            want[1] = ($urandom_range(0, 3) != 0);
            cyc(1, $urandom_range(0, 2) != 0,
                ($urandom_range(0, 1) == 1) && (m_q.size() > 0), $urandom);
        end
        drain();

        // same-cycle addr_ok + data_ok with an empty FIFO
        want[1] = 1;
        cyc(1, 1, 1, 32'h1234_5678);
        want[1] = 0;
        cyc(1, 0, 0, 0);

        // data_ok with nothing outstanding sets the sticky error
        cyc(1, 0, 1, 32'hBAD0_0000);
        repeat (3) cyc(1, 0, 0, 0);

        // reset clears the error
        want[0] = 1; want[1] = 1;
        repeat (2) cyc(0, 1, 1, 32'h0);
        want[0] = 0; want[1] = 0;
        cyc(1, 0, 0, 0);

        chk("scoreboard_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
